hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Load-use and branch-operand hazard detector with a multi-cycle stall FSM for the MIPS pipeline.
//  Sits beside the ID stage and compares ID source registers against EX/MEM destinations.
//  Drives PC/IF-ID hold and the ID-EX bubble for N cycles, with N set by memory latency and hazard kind.
//  Counts stall cycles for the debug unit.
// PARAMETERS
//  NB_REG_ADDR   5   register address width
//  LOAD_LATENCY  1   load-use stall cycles (1..6); branch-after-load costs LOAD_LATENCY+1
//  NB_STALL_CNT  32  width of saturating stall-cycle counter
// PORTS
//  i_clock        in   1            clock, rising edge
//  i_reset        in   1            asynchronous, active-low reset
//  i_enable       in   1            pipeline advance (debug step); low freezes block
//  i_flush        in   1            taken branch/jump flush; aborts any stall
//  i_id_rs        in   NB_REG_ADDR  ID source rs
//  i_id_rt        in   NB_REG_ADDR  ID source rt
//  i_id_use_rs    in   1            ID instr reads rs
//  i_id_use_rt    in   1            ID instr reads rt
//  i_id_branch    in   1            ID instr is BEQ/BNE (compares in ID)
//  i_ex_rd        in   NB_REG_ADDR  EX destination register
//  i_ex_we        in   1            EX instr writes register file
//  i_ex_re        in   1            EX instr is a load
//  i_mem_rd       in   NB_REG_ADDR  MEM destination register
//  i_mem_re       in   1            MEM instr is a load
//  o_hazard       out  1            stall active this cycle (= o_hold_pc)
//  o_hold_pc      out  1            PC write inhibit
//  o_hold_ifid    out  1            IF/ID write inhibit
//  o_bubble_idex  out  1            ID/EX loads NOP control
//  o_stall_cnt    out  NB_STALL_CNT total stall cycles, saturating
// BEHAVIOUR
//  Match rules: mX_rs = use_rs & (rs==X_rd) & (X_rd!=0); same for rt; mX = mX_rs|mX_rt.
//  Required stalls N (highest priority wins):
//   branch & ex_re & mEX -> LOAD_LATENCY+1
//   ex_re & mEX -> LOAD_LATENCY
//   branch & ex_we & !ex_re & mEX -> 1
//   branch & mem_re & mMEM -> 1
//   else 0
//  FSM states: IDLE, STALL. Register cnt, width clog2(LOAD_LATENCY+2).
//  IDLE: N>0 & enable & !flush -> outputs asserted this cycle (Mealy); cnt<=N-1.
//   If N-1>0, go to STALL; else stay IDLE.
//  STALL: all three hold/bubble outputs asserted (Moore). Hazard inputs are ignored;
//   a bubble has already replaced EX, so re-detection is suppressed.
//   On each enabled cycle cnt<=cnt-1. Go to IDLE when cnt==1 is consumed.
//  Next cycle in IDLE re-evaluates inputs normally, so back-to-back hazards chain with no gap.
//  i_flush (any state): outputs 0 that cycle; state<=IDLE; cnt<=0. Flush beats a new hazard.
//  i_enable low: state, cnt and o_stall_cnt hold. Outputs still reflect current state:
//   STALL -> 1; IDLE -> 0 (no Mealy assert while frozen).
//  o_stall_cnt += 1 on every enabled cycle with o_hazard=1. Saturates at all-ones; never wraps.
//  Reset (async, any time, including mid-stall): state=IDLE, cnt=0, o_stall_cnt=0, all outputs 0.
//  Release is synchronous to i_clock.
//  Register $0 never causes a hazard. Outputs hold and bubble always assert together.
// TESTING
//  1 LW r5 in EX (ex_re=1,ex_rd=5), ID ADD use_rs rs=5, LOAD_LATENCY=1
//    -> 1 stall cycle, then deasserted; stall_cnt=1.
//  2 Same with LOAD_LATENCY=3, id_branch=1
//    -> 4 consecutive stall cycles. Mid-stall enable=0 for 2 cycles -> outputs held, cnt frozen.
//  3 BEQ rt=7 in ID, EX ADD ex_we=1 ex_rd=7 -> 1 stall.
//    Then MEM load mem_rd=7 with no EX hazard -> 1 more stall, chained back-to-back.
//  4 ex_rd=0 ex_re=1 with rs=0 -> no stall.
//    use_rs=0 with rs==ex_rd -> no stall.
//  5 Stall in progress (LOAD_LATENCY=3, cycle 2 of 4), i_flush=1
//    -> outputs 0 that cycle, IDLE next; stall_cnt excludes the flush cycle.
//  6 Assert i_reset=0 mid-stall -> outputs and counter 0 immediately.
//    Force stall_cnt to near max (NB_STALL_CNT=4) -> saturates at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand hazard detector beside the ID stage. It holds PC and IF/ID
// and bubbles ID/EX for N cycles, and keeps a saturating count of stall cycles for debug.
module hazard_stall_ctrl #(
  parameter int NB_REG_ADDR  = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int NB_STALL_CNT = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_flush,
  input  logic [NB_REG_ADDR-1:0]  i_id_rs,
  input  logic [NB_REG_ADDR-1:0]  i_id_rt,
  input  logic                    i_id_use_rs,
  input  logic                    i_id_use_rt,
  input  logic                    i_id_branch,
  input  logic [NB_REG_ADDR-1:0]  i_ex_rd,
  input  logic                    i_ex_we,
  input  logic                    i_ex_re,
  input  logic [NB_REG_ADDR-1:0]  i_mem_rd,
  input  logic                    i_mem_re,
  output logic                    o_hazard,
  output logic                    o_hold_pc,
  output logic                    o_hold_ifid,
  output logic                    o_bubble_idex,
  output logic [NB_STALL_CNT-1:0] o_stall_cnt
);

  // state | meaning
  // IDLE  | no stall in progress; a detected hazard asserts outputs this cycle (Mealy)
  // STALL | remaining stall cycles in cnt; outputs asserted, hazard inputs ignored

  localparam int CW = $clog2(LOAD_LATENCY + 2);
  localparam logic [CW-1:0] N_ONE     = CW'(1);
  localparam logic [CW-1:0] N_LOAD    = CW'(LOAD_LATENCY);
  localparam logic [CW-1:0] N_BR_LOAD = CW'(LOAD_LATENCY + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [CW-1:0]       need;
  logic                m_ex, m_mem;
  logic                stall;

  always_comb begin
    m_ex  = (i_id_use_rs & (i_id_rs == i_ex_rd)  & (i_ex_rd  != '0)) |
            (i_id_use_rt & (i_id_rt == i_ex_rd)  & (i_ex_rd  != '0));
    m_mem = (i_id_use_rs & (i_id_rs == i_mem_rd) & (i_mem_rd != '0)) |
            (i_id_use_rt & (i_id_rt == i_mem_rd) & (i_mem_rd != '0));
    need = '0;
    if (i_id_branch & i_ex_re & m_ex)
      need = N_BR_LOAD;
    else if (i_ex_re & m_ex)
      need = N_LOAD;
    else if (i_id_branch & i_ex_we & m_ex)
      need = N_ONE;
    else if (i_id_branch & i_mem_re & m_mem)
      need = N_ONE;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    if (i_flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable && need != '0) begin
            stall    = 1'b1;
            cnt_next = need - N_ONE;
            if (need != N_ONE) state_next = STALL;
          end
        end
        STALL: begin
          stall = 1'b1;
          if (i_enable) begin
            cnt_next = cnt - N_ONE;
            if (cnt == N_ONE) state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (i_enable || i_flush) begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Saturating; a flush cycle never counts because stall is forced low.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      o_stall_cnt <= '0;
    else if (i_enable && stall && o_stall_cnt != '1)
      o_stall_cnt <= o_stall_cnt + 1'b1;
  end

  assign o_hazard      = stall;
  assign o_hold_pc     = stall;
  assign o_hold_ifid   = stall;
  assign o_bubble_idex = stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with LOAD_LATENCY=1 and a 4-bit
// counter (a), one with LOAD_LATENCY=3 and a 32-bit counter (b), sharing stimulus.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, flush;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       use_rs, use_rt, branch, ex_we, ex_re, mem_re;

  logic        a_hazard, a_hold_pc, a_hold_ifid, a_bubble;
  logic [3:0]  a_cnt;
  logic        b_hazard, b_hold_pc, b_hold_ifid, b_bubble;
  logic [31:0] b_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.NB_REG_ADDR(5), .LOAD_LATENCY(1), .NB_STALL_CNT(4)) u_a (
    .i_clock(clk), .i_reset(rst_n), .i_enable(enable), .i_flush(flush),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
    .i_id_branch(branch), .i_ex_rd(ex_rd), .i_ex_we(ex_we), .i_ex_re(ex_re),
    .i_mem_rd(mem_rd), .i_mem_re(mem_re),
    .o_hazard(a_hazard), .o_hold_pc(a_hold_pc), .o_hold_ifid(a_hold_ifid),
    .o_bubble_idex(a_bubble), .o_stall_cnt(a_cnt)
  );

  hazard_stall_ctrl #(.NB_REG_ADDR(5), .LOAD_LATENCY(3), .NB_STALL_CNT(32)) u_b (
    .i_clock(clk), .i_reset(rst_n), .i_enable(enable), .i_flush(flush),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
    .i_id_branch(branch), .i_ex_rd(ex_rd), .i_ex_we(ex_we), .i_ex_re(ex_re),
    .i_mem_rd(mem_rd), .i_mem_re(mem_re),
    .o_hazard(b_hazard), .o_hold_pc(b_hold_pc), .o_hold_ifid(b_hold_ifid),
    .o_bubble_idex(b_bubble), .o_stall_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs_a();
    return {a_hazard, a_hold_pc, a_hold_ifid, a_bubble};
  endfunction

  function automatic logic [3:0] outs_b();
    return {b_hazard, b_hold_pc, b_hold_ifid, b_bubble};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    use_rs = 0; use_rt = 0; branch = 0; ex_we = 0; ex_re = 0; mem_re = 0;
    flush = 0; enable = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_load_use(input logic br);
    ex_re = 1; ex_we = 1; ex_rd = 5'd5; id_rs = 5'd5; use_rs = 1; branch = br;
    #1;
  endtask

  initial begin
    do_reset();
    check("reset_outs_a", 32'(outs_a()), 32'h0);
    check("reset_outs_b", 32'(outs_b()), 32'h0);
    check("reset_cnt_a", 32'(a_cnt), 32'd0);

    // 1: LW r5 in EX, ADD uses r5, LOAD_LATENCY=1 -> single stall
    do_reset();
    set_load_use(1'b0);
    check("t1_stall", 32'(outs_a()), 32'hF);
    tick();
    clear_inputs(); #1;
    check("t1_release", 32'(outs_a()), 32'h0);
    check("t1_cnt", 32'(a_cnt), 32'd1);

    // 2: branch after load, LOAD_LATENCY=3 -> 4 stalls, frozen 2 cycles mid-stall
    do_reset();
    set_load_use(1'b1);
    check("t2_c1", 32'(outs_b()), 32'hF);
    tick();
    clear_inputs(); #1;
    check("t2_c2", 32'(outs_b()), 32'hF);
    tick();
    enable = 0;
    set_load_use(1'b0);
    check("t2_frz1", 32'(outs_b()), 32'hF);
    check("t2_frz_idle_a", 32'(outs_a()), 32'h0);
    tick();
    check("t2_frz2", 32'(outs_b()), 32'hF);
    check("t2_frz_cnt", b_cnt, 32'd2);
    tick();
    clear_inputs(); #1;
    check("t2_c3", 32'(outs_b()), 32'hF);
    tick();
    check("t2_c4", 32'(outs_b()), 32'hF);
    tick();
    check("t2_release", 32'(outs_b()), 32'h0);
    check("t2_cnt", b_cnt, 32'd4);

    // 3: BEQ rt=7 vs EX ADD r7, then MEM load r7 -> two chained single stalls
    do_reset();
    branch = 1; use_rt = 1; id_rt = 5'd7; ex_we = 1; ex_rd = 5'd7; #1;
    check("t3_ex", 32'(outs_a()), 32'hF);
    tick();
    ex_we = 0; ex_rd = 5'd0; mem_re = 1; mem_rd = 5'd7; #1;
    check("t3_mem", 32'(outs_a()), 32'hF);
    tick();
    clear_inputs(); #1;
    check("t3_release", 32'(outs_a()), 32'h0);
    check("t3_cnt", 32'(a_cnt), 32'd2);

    // 4: register $0, unused source, non-branch MEM load -> no stall
    do_reset();
    ex_re = 1; ex_we = 1; ex_rd = 5'd0; id_rs = 5'd0; use_rs = 1; #1;
    check("t4_r0_a", 32'(outs_a()), 32'h0);
    check("t4_r0_b", 32'(outs_b()), 32'h0);
    ex_rd = 5'd9; id_rs = 5'd9; use_rs = 0; use_rt = 1; id_rt = 5'd3; #1;
    check("t4_unused_rs", 32'(outs_a()), 32'h0);
    ex_re = 0; ex_we = 0; ex_rd = 5'd0; mem_re = 1; mem_rd = 5'd9; use_rs = 1; #1;
    check("t4_mem_nobranch", 32'(outs_a()), 32'h0);
    tick();
    check("t4_cnt", 32'(a_cnt), 32'd0);

    // 5: flush in cycle 2 of a 4-cycle stall
    do_reset();
    set_load_use(1'b1);
    check("t5_c1", 32'(outs_b()), 32'hF);
    tick();
    clear_inputs();
    flush = 1; #1;
    check("t5_flush", 32'(outs_b()), 32'h0);
    tick();
    flush = 0; #1;
    check("t5_idle", 32'(outs_b()), 32'h0);
    check("t5_cnt", b_cnt, 32'd1);
    tick();
    check("t5_idle2", 32'(outs_b()), 32'h0);

    // 6: async reset mid-stall, then saturation of the 4-bit counter
    do_reset();
    set_load_use(1'b1);
    tick();
    clear_inputs(); #1;
    check("t6_mid", 32'(outs_b()), 32'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", 32'(outs_b()), 32'h0);
    check("t6_rst_cnt", b_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    set_load_use(1'b0);
    for (int i = 0; i < 14; i++) tick();
    check("t6_cnt14", 32'(a_cnt), 32'd14);
    check("t6_held_stall", 32'(outs_a()), 32'hF);
    for (int i = 0; i < 6; i++) tick();
    check("t6_sat", 32'(a_cnt), 32'd15);
    clear_inputs();
    tick();
    check("t6_sat_hold", 32'(a_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
